boss_health_bar_renderer: RTL and testbench



---
 rtl/boss_health_bar_renderer.sv | 113 +++++++++++
 tb/tb_boss_health_bar_renderer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/boss_health_bar_renderer.sv
// boss_health_bar_renderer: redraws the boss health bar through the shared VGA plotter.
// Optional HEALTH_BAR_BORDER_EN adds a 1-pixel BORDER_COLOUR ring around the interior.
module boss_health_bar_renderer #(
   parameter logic [5:0] MAX_HEALTH    = 6'd60,
   parameter int         SCALE         = 2,
   parameter logic [7:0] BAR_X0        = 8'd20,
   parameter logic [6:0] BAR_Y0        = 7'd4,
   parameter int         BAR_H         = 4,
   parameter logic [2:0] FG_COLOUR     = 3'b100,
`ifdef HEALTH_BAR_BORDER_EN
   parameter logic [2:0] BORDER_COLOUR = 3'b111,
`endif
   parameter logic [2:0] BG_COLOUR     = 3'b000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [5:0] health_length,
   output logic       draw_req,
   input  logic       draw_gnt,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       draw_done
);
   localparam int W = int'(MAX_HEALTH) * SCALE;
`ifdef HEALTH_BAR_BORDER_EN
   localparam int OFS = 1;
`else
   localparam int OFS = 0;
`endif
   localparam int COLS = W + 2 * OFS;
   localparam int ROWS = BAR_H + 2 * OFS;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t     r_state, w_next;
   logic [7:0] r_col;
   logic [6:0] r_row;
   logic [5:0] r_frame_h, r_drawn_h;
   logic       r_init_pending;
   logic [5:0] w_h;
   logic       w_pending, w_accept, w_last, w_row_end;
   logic [7:0] w_ic, w_fill;
   logic [2:0] w_colour;

   assign w_h       = (health_length > MAX_HEALTH) ? MAX_HEALTH : health_length;
   assign w_pending = r_init_pending || (w_h != r_drawn_h);
   assign w_accept  = (r_state == DRAW) && draw_gnt;
   assign w_row_end = r_col == 8'(COLS - 1);
   assign w_last    = w_row_end && (r_row == 7'(ROWS - 1));
   // w_ic is the interior column; with a border it wraps at col 0, which the ring overrides
   assign w_ic      = r_col - 8'(OFS);
   assign w_fill    = 8'(int'(r_frame_h) * SCALE);
`ifdef HEALTH_BAR_BORDER_EN
   assign w_colour  = (r_col == 8'd0 || w_row_end || r_row == 7'd0 || r_row == 7'(ROWS - 1))
                      ? BORDER_COLOUR : (w_ic < w_fill) ? FG_COLOUR : BG_COLOUR;
`else
   assign w_colour  = (w_ic < w_fill) ? FG_COLOUR : BG_COLOUR;
`endif

   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? (w_pending ? DRAW : IDLE) :
               (r_state == DRAW) ? ((w_accept && w_last) ? DONE : DRAW) : IDLE;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_col          <= '0;
         r_row          <= '0;
         r_frame_h      <= '0;
         r_drawn_h      <= '0;
         r_init_pending <= 1'b1;
         draw_req       <= 1'b0;
         vga_x          <= '0;
         vga_y          <= '0;
         vga_colour     <= '0;
         vga_plot       <= 1'b0;
         busy           <= 1'b0;
         draw_done      <= 1'b0;
      end else begin
         vga_plot  <= w_accept;
         draw_done <= r_state == DONE;
         if (r_state == IDLE && w_pending) begin
            r_frame_h <= w_h;
            r_col     <= '0;
            r_row     <= '0;
            busy      <= 1'b1;
            draw_req  <= 1'b1;
         end
         if (w_accept) begin
            vga_x      <= BAR_X0 + r_col - 8'(OFS);
            vga_y      <= BAR_Y0 + r_row - 7'(OFS);
            vga_colour <= w_colour;
            r_col      <= w_row_end ? 8'd0 : r_col + 8'd1;
            r_row      <= w_row_end ? r_row + 7'd1 : r_row;
            if (w_last) draw_req <= 1'b0;
         end
         if (r_state == DONE) begin
            busy           <= 1'b0;
            r_drawn_h      <= r_frame_h;
            r_init_pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_boss_health_bar_renderer.sv
// tb_boss_health_bar_renderer: directed scenarios for the boss health bar renderer.
module tb_boss_health_bar_renderer;
`ifdef HEALTH_BAR_BORDER_EN
   localparam int OFS = 1;
   localparam logic [17:0] FIRST_FULL = {8'd19, 7'd3, 3'b111};
   localparam logic [17:0] LAST_FULL  = {8'd140, 7'd8, 3'b111};
`else
   localparam int OFS = 0;
   localparam logic [17:0] FIRST_FULL = {8'd20, 7'd4, 3'b100};
   localparam logic [17:0] LAST_FULL  = {8'd139, 7'd7, 3'b100};
`endif
   localparam int COLS = 120 + 2 * OFS;
   localparam int ROWS = 4 + 2 * OFS;
   localparam int NPIX = COLS * ROWS;

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b1;
   logic [5:0] health_length = 6'd60;
   logic       draw_gnt = 1'b1;
   logic       draw_req, vga_plot, busy, draw_done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   logic [17:0] cap [0:2047];
   int          np, ndone, bad_plot, checks, errors;
   logic        prev_gnt;

   boss_health_bar_renderer dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .health_length(health_length),
      .draw_req(draw_req), .draw_gnt(draw_gnt), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .draw_done(draw_done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) prev_gnt <= draw_gnt;

   always @(negedge CLOCK_50) begin
      if (vga_plot) begin
         if (np < 2048) cap[np] = {vga_x, vga_y, vga_colour};
         np = np + 1;
         if (!prev_gnt) bad_plot = bad_plot + 1;
      end
      if (draw_done) ndone = ndone + 1;
   end

   // Reference pixel i of a frame drawn with raw health h
   function automatic logic [17:0] exp_pix(input int i, input int h);
      int c, r, hc;
      logic [2:0] col;
      c   = i % COLS;
      r   = i / COLS;
      hc  = (h > 60) ? 60 : h;
      col = ((c - OFS) < hc * 2) ? 3'b100 : 3'b000;
      if (OFS == 1 && (c == 0 || c == COLS - 1 || r == 0 || r == ROWS - 1)) col = 3'b111;
      return {8'(20 - OFS + c), 7'(4 - OFS + r), col};
   endfunction

   task automatic wait_frames(input int target, input bit toggle);
      for (int c = 0; c < 6000 && ndone < target; c++) begin
         @(negedge CLOCK_50);
         if (toggle) draw_gnt = ~draw_gnt;
      end
      draw_gnt = 1'b1;
   endtask

   task automatic test_reset;
      #2 resetn = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      checks++;
      if ({draw_req, vga_plot, busy, draw_done, vga_x, vga_y, vga_colour} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {draw_req, vga_plot, busy, draw_done, vga_x, vga_y, vga_colour});
      end
      np = 0; ndone = 0; bad_plot = 0;
      resetn = 1'b1;
      @(negedge CLOCK_50);
      checks++;
      if ({draw_req, busy, vga_plot} !== 3'b110) begin
         errors++;
         $display("FAIL req_after_release got %b want 110", {draw_req, busy, vga_plot});
      end
      wait_frames(1, 0);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL full_count got %0d want %0d", np, NPIX); end
      checks++;
      if (cap[0] !== FIRST_FULL) begin errors++; $display("FAIL full_first got %h want %h", cap[0], FIRST_FULL); end
      checks++;
      if (cap[NPIX-1] !== LAST_FULL) begin errors++; $display("FAIL full_last got %h want %h", cap[NPIX-1], LAST_FULL); end
      repeat (20) @(negedge CLOCK_50);
      checks++;
      if ({ndone, np, draw_req, busy} !== {32'd1, 32'(NPIX), 2'b00}) begin
         errors++;
         $display("FAIL idle_after_full got done=%0d np=%0d req=%b busy=%b want 1 %0d 0 0",
                  ndone, np, draw_req, busy, NPIX);
      end
   endtask

   task automatic test_half;
      np = 0; ndone = 0;
      health_length = 6'd30;
      wait_frames(1, 0);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL half_count got %0d want %0d", np, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (cap[i] !== exp_pix(i, 30)) begin
            errors++;
            $display("FAIL half_pix%0d got %h want %h", i, cap[i], exp_pix(i, 30));
         end
      end
   endtask

   task automatic test_mid_change;
      np = 0; ndone = 0;
      health_length = 6'd60;
      for (int c = 0; c < 2000 && np < 200; c++) @(negedge CLOCK_50);
      checks++;
      if (np < 200) begin errors++; $display("FAIL mid_reach200 got %0d want 200", np); end
      health_length = 6'd59;
      wait_frames(2, 0);
      checks++;
      if (np !== 2 * NPIX) begin errors++; $display("FAIL mid_count got %0d want %0d", np, 2 * NPIX); end
      for (int i = 0; i < 2 * NPIX; i++) begin
         checks++;
         if (cap[i] !== exp_pix(i % NPIX, (i < NPIX) ? 60 : 59)) begin
            errors++;
            $display("FAIL mid_pix%0d got %h want %h", i, cap[i], exp_pix(i % NPIX, (i < NPIX) ? 60 : 59));
         end
      end
   endtask

   task automatic test_gnt_toggle;
      np = 0; ndone = 0; bad_plot = 0;
      health_length = 6'd45;
      wait_frames(1, 1);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL toggle_count got %0d want %0d", np, NPIX); end
      checks++;
      if (bad_plot !== 0) begin errors++; $display("FAIL toggle_plot_without_gnt got %0d want 0", bad_plot); end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (cap[i] !== exp_pix(i, 45)) begin
            errors++;
            $display("FAIL toggle_pix%0d got %h want %h", i, cap[i], exp_pix(i, 45));
         end
      end
   endtask

   task automatic test_reset_mid;
      np = 0; ndone = 0;
      health_length = 6'd60;
      for (int c = 0; c < 2000 && np < 100; c++) @(negedge CLOCK_50);
      resetn = 1'b0;
      #1;
      checks++;
      if ({vga_plot, draw_req, busy} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got %b want 000", {vga_plot, draw_req, busy});
      end
      @(negedge CLOCK_50);
      np = 0; ndone = 0;
      resetn = 1'b1;
      wait_frames(1, 0);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL restart_count got %0d want %0d", np, NPIX); end
      checks++;
      if (cap[0] !== FIRST_FULL) begin errors++; $display("FAIL restart_first got %h want %h", cap[0], FIRST_FULL); end
   endtask

   task automatic test_clamp;
      np = 0; ndone = 0;
      health_length = 6'd0;
      wait_frames(1, 0);
      np = 0; ndone = 0;
      health_length = 6'd63;
      wait_frames(1, 0);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL clamp_count got %0d want %0d", np, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (cap[i] !== exp_pix(i, 63)) begin
            errors++;
            $display("FAIL clamp_pix%0d got %h want %h", i, cap[i], exp_pix(i, 63));
         end
      end
      repeat (50) @(negedge CLOCK_50);
      checks++;
      if ({ndone, np, draw_req} !== {32'd1, 32'(NPIX), 1'b0}) begin
         errors++;
         $display("FAIL clamp_no_redraw got done=%0d np=%0d req=%b want 1 %0d 0", ndone, np, draw_req, NPIX);
      end
   endtask

   task automatic test_zero;
      np = 0; ndone = 0;
      health_length = 6'd0;
      wait_frames(1, 0);
      checks++;
      if (np !== NPIX) begin errors++; $display("FAIL zero_count got %0d want %0d", np, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (cap[i] !== exp_pix(i, 0)) begin
            errors++;
            $display("FAIL zero_pix%0d got %h want %h", i, cap[i], exp_pix(i, 0));
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      np = 0; ndone = 0; bad_plot = 0;
      test_reset;
      test_half;
      test_mid_change;
      test_gnt_toggle;
      test_reset_mid;
      test_clamp;
      test_zero;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
